ascii_num_parser: RTL and testbench

//  Byte-level tokenizer between the UART receiver and Input_Subsystem. Consumes received

---
 rtl/ascii_num_parser.sv | 203 ++++++++++++++++++++
 tb/tb_ascii_num_parser.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ascii_num_parser.sv
// ---------------------------------------------------------------------------
// ascii_num_parser
//   Byte-level tokenizer between the UART receiver and the input subsystem.
//   It turns a stream of ASCII bytes into unsigned decimal numbers, each
//   flagged by a one-cycle valid pulse. It also reports line terminators and
//   rejected tokens, so downstream logic deals only with numbers and error
//   events. Every output is registered, so a response appears one cycle
//   after the byte that caused it.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_en         parser enable; when low the parser is held idle and cleared
//   i_rx_valid   one-cycle pulse: i_rx_data holds a new byte
//   i_rx_data    received ASCII byte
//   i_flush      ends a pending number without a delimiter (honoured only
//                in cycles where i_rx_valid is low)
//   o_num_valid  one-cycle pulse: o_num holds a complete token
//   o_num        parsed value; holds until the next o_num_valid
//   o_line_end   one-cycle pulse on a line terminator (CRLF counts once)
//   o_tok_cnt    tokens emitted on the current line, saturating at 255
//   o_err        one-cycle pulse: token rejected
//   o_err_code   01 illegal character, 10 value above MAX_VAL; holds
//   o_busy       high while a number is partially accumulated
// ---------------------------------------------------------------------------
module ascii_num_parser #(
  parameter int DATA_W  = 32,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_flush,
  output logic              o_num_valid,
  output logic [DATA_W-1:0] o_num,
  output logic              o_line_end,
  output logic [7:0]        o_tok_cnt,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_SKIP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic              r_last_cr, w_last_cr_nxt;
  logic              r_num_valid, w_num_valid_nxt;
  logic [DATA_W-1:0] r_num, w_num_nxt;
  logic              r_line_end, w_line_end_nxt;
  logic [7:0]        r_tok_cnt, w_tok_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_err_code, w_err_code_nxt;

  // Byte classification
  logic w_is_digit, w_is_cr, w_is_lf, w_is_blank, w_is_delim, w_line_term;
  assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
  assign w_is_cr    = (i_rx_data == 8'h0D);
  assign w_is_lf    = (i_rx_data == 8'h0A);
  assign w_is_blank = (i_rx_data == 8'h20) || (i_rx_data == 8'h09);
  assign w_is_delim = w_is_blank || w_is_cr || w_is_lf;
  // An LF directly after a CR belongs to the same terminator.
  assign w_line_term = w_is_cr || (w_is_lf && !r_last_cr);

  // One extra bit of headroom: acc never exceeds MAX_VAL, so acc*10+9
  // always fits and the range check cannot be fooled by wrap-around.
  logic [DATA_W:0]   w_acc_ext;
  logic [DATA_W:0]   w_digit_ext;
  logic [DATA_W:0]   w_acc_mul;
  logic              w_over;
  logic [DATA_W-1:0] w_digit_val;
  assign w_acc_ext   = {1'b0, r_acc};
  assign w_digit_ext = (DATA_W+1)'(i_rx_data[3:0]);
  assign w_acc_mul   = (w_acc_ext * (DATA_W+1)'(10)) + w_digit_ext;
  assign w_over      = (w_acc_mul > (DATA_W+1)'(MAX_VAL));
  assign w_digit_val = DATA_W'(i_rx_data[3:0]);

  logic       w_emit;
  logic [7:0] w_cnt_base;

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_last_cr_nxt   = r_last_cr;
    w_num_valid_nxt = 1'b0;
    w_num_nxt       = r_num;
    w_line_end_nxt  = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_emit          = 1'b0;

    if (!i_en) begin
      w_state_nxt   = S_IDLE;
      w_acc_nxt     = '0;
      w_last_cr_nxt = 1'b0;
    end else if (i_rx_valid) begin
      w_last_cr_nxt  = w_is_cr;
      // Terminators are reported in every state, including SKIP, so the
      // consumer can resynchronise on line boundaries.
      w_line_end_nxt = w_line_term;
      unique case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            w_acc_nxt   = w_digit_val;
            w_state_nxt = S_NUM;
          end else if (!w_is_delim) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_ILLEGAL;
            w_state_nxt    = S_SKIP;
          end
        end
        S_NUM: begin
          if (w_is_digit) begin
            if (w_over) begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_RANGE;
              w_state_nxt    = S_SKIP;
            end else begin
              w_acc_nxt = w_acc_mul[DATA_W-1:0];
            end
          end else if (w_is_delim) begin
            w_emit      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_ILLEGAL;
            w_state_nxt    = S_SKIP;
          end
        end
        S_SKIP: begin
          if (w_is_delim) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (i_flush) begin
      if (r_state == S_NUM) begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end else if (r_state == S_SKIP) begin
        w_state_nxt = S_IDLE;
      end
    end

    if (w_emit) begin
      w_num_valid_nxt = 1'b1;
      w_num_nxt       = r_acc;
    end

    // The count restarts the cycle after a line-end pulse was shown.
    w_cnt_base = r_line_end ? 8'd0 : r_tok_cnt;
    if (!i_en) begin
      w_tok_cnt_nxt = 8'd0;
    end else if (w_emit && (w_cnt_base != 8'd255)) begin
      w_tok_cnt_nxt = w_cnt_base + 8'd1;
    end else begin
      w_tok_cnt_nxt = w_cnt_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_last_cr   <= 1'b0;
      r_num_valid <= 1'b0;
      r_num       <= '0;
      r_line_end  <= 1'b0;
      r_tok_cnt   <= 8'd0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_last_cr   <= w_last_cr_nxt;
      r_num_valid <= w_num_valid_nxt;
      r_num       <= w_num_nxt;
      r_line_end  <= w_line_end_nxt;
      r_tok_cnt   <= w_tok_cnt_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  assign o_num_valid = r_num_valid;
  assign o_num       = r_num;
  assign o_line_end  = r_line_end;
  assign o_tok_cnt   = r_tok_cnt;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_busy      = (r_state == S_NUM);

endmodule

// File: tb/tb_ascii_num_parser.sv
module tb_ascii_num_parser;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_en;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              i_flush;
  logic              o_num_valid;
  logic [DATA_W-1:0] o_num;
  logic              o_line_end;
  logic [7:0]        o_tok_cnt;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic              o_busy;

  int total = 0;
  int bad   = 0;

  ascii_num_parser #(.DATA_W(DATA_W), .MAX_VAL(9999)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .i_flush     (i_flush),
    .o_num_valid (o_num_valid),
    .o_num       (o_num),
    .o_line_end  (o_line_end),
    .o_tok_cnt   (o_tok_cnt),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Presents one byte for one cycle; returns 1 time unit after the edge that
  // registered it, so the outputs seen on return are the response to it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    $display("tx byte 0x%02h -> nv=%0b num=%0d le=%0b cnt=%0d err=%0b code=%0b busy=%0b",
             b, o_num_valid, o_num, o_line_end, o_tok_cnt, o_err, o_err_code, o_busy);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_en = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({o_num_valid, o_line_end, o_err, o_busy} !== 4'b0000) begin bad++; $display("FAIL rst_pulses got=%b exp=0000", {o_num_valid, o_line_end, o_err, o_busy}); end
    total++; if (o_num !== '0) begin bad++; $display("FAIL rst_num got=%0d exp=0", o_num); end
    total++; if (o_tok_cnt !== 8'd0 || o_err_code !== 2'b00) begin bad++; $display("FAIL rst_cnt_code got=%0d/%b exp=0/00", o_tok_cnt, o_err_code); end
    rst_n = 1'b1; i_en = 1'b1;
  endtask

  task automatic test_line;
    send_byte("1"); send_byte("2"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd12) begin bad++; $display("FAIL line_tok12 got nv=%0b num=%0d exp nv=1 num=12", o_num_valid, o_num); end
    total++; if (o_tok_cnt !== 8'd1 || o_line_end !== 1'b0) begin bad++; $display("FAIL line_cnt1 got cnt=%0d le=%0b exp cnt=1 le=0", o_tok_cnt, o_line_end); end
    send_byte("3"); send_byte("4"); send_byte(8'h0D);
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd34 || o_line_end !== 1'b1) begin bad++; $display("FAIL line_tok34 got nv=%0b num=%0d le=%0b exp 1/34/1", o_num_valid, o_num, o_line_end); end
    total++; if (o_tok_cnt !== 8'd2) begin bad++; $display("FAIL line_cnt2 got=%0d exp=2", o_tok_cnt); end
    send_byte(8'h0A);
    total++; if (o_line_end !== 1'b0 || o_num_valid !== 1'b0) begin bad++; $display("FAIL line_lf_suppr got le=%0b nv=%0b exp 0/0", o_line_end, o_num_valid); end
    total++; if (o_tok_cnt !== 8'd0) begin bad++; $display("FAIL line_cnt_clr got=%0d exp=0", o_tok_cnt); end
  endtask

  task automatic test_illegal;
    send_byte("1");
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL ill_busy got=%0b exp=1", o_busy); end
    send_byte("a");
    total++; if (o_err !== 1'b1 || o_err_code !== 2'b01 || o_num_valid !== 1'b0) begin bad++; $display("FAIL ill_err got err=%0b code=%b nv=%0b exp 1/01/0", o_err, o_err_code, o_num_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ill_busy_drop got=%0b exp=0", o_busy); end
    send_byte(" ");
    total++; if (o_num_valid !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL ill_no_tok got nv=%0b err=%0b exp 0/0", o_num_valid, o_err); end
    send_byte("5"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd5 || o_tok_cnt !== 8'd1) begin bad++; $display("FAIL ill_tok5 got nv=%0b num=%0d cnt=%0d exp 1/5/1", o_num_valid, o_num, o_tok_cnt); end
  endtask

  task automatic test_range;
    send_byte("9"); send_byte("9"); send_byte("9"); send_byte("9"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd9999 || o_tok_cnt !== 8'd2) begin bad++; $display("FAIL rng_max got nv=%0b num=%0d cnt=%0d exp 1/9999/2", o_num_valid, o_num, o_tok_cnt); end
    for (int i = 0; i < 4; i++) send_byte("9");
    total++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL rng_4dig got err=%0b busy=%0b exp 0/1", o_err, o_busy); end
    send_byte("9");
    total++; if (o_err !== 1'b1 || o_err_code !== 2'b10 || o_num_valid !== 1'b0) begin bad++; $display("FAIL rng_over got err=%0b code=%b nv=%0b exp 1/10/0", o_err, o_err_code, o_num_valid); end
    total++; if (o_num !== 32'd9999) begin bad++; $display("FAIL rng_num_hold got=%0d exp=9999", o_num); end
    send_byte(" "); send_byte("0"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd0 || o_tok_cnt !== 8'd3) begin bad++; $display("FAIL rng_tok0 got nv=%0b num=%0d cnt=%0d exp 1/0/3", o_num_valid, o_num, o_tok_cnt); end
    total++; if (o_err_code !== 2'b10 || o_err !== 1'b0) begin bad++; $display("FAIL rng_code_hold got code=%b err=%0b exp 10/0", o_err_code, o_err); end
    send_byte("0"); send_byte("0"); send_byte("7"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd7) begin bad++; $display("FAIL rng_lead0 got nv=%0b num=%0d exp 1/7", o_num_valid, o_num); end
  endtask

  task automatic test_flush;
    send_byte("4"); send_byte("2");
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL fl_busy got=%0b exp=1", o_busy); end
    @(posedge clk); #1; i_flush = 1'b1;
    @(posedge clk); #1; i_flush = 1'b0;
    $display("flush -> nv=%0b num=%0d le=%0b cnt=%0d busy=%0b", o_num_valid, o_num, o_line_end, o_tok_cnt, o_busy);
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd42 || o_line_end !== 1'b0) begin bad++; $display("FAIL fl_tok42 got nv=%0b num=%0d le=%0b exp 1/42/0", o_num_valid, o_num, o_line_end); end
    total++; if (o_busy !== 1'b0 || o_tok_cnt !== 8'd5) begin bad++; $display("FAIL fl_busy_cnt got busy=%0b cnt=%0d exp 0/5", o_busy, o_tok_cnt); end
    @(posedge clk); #1;
    total++; if (o_num_valid !== 1'b0) begin bad++; $display("FAIL fl_pulse_len got=%0b exp=0", o_num_valid); end
  endtask

  task automatic test_enable;
    send_byte("7"); send_byte("8");
    @(posedge clk); #1; i_en = 1'b0;
    @(posedge clk); #1; i_en = 1'b1;
    $display("en drop -> nv=%0b num=%0d cnt=%0d busy=%0b", o_num_valid, o_num, o_tok_cnt, o_busy);
    total++; if (o_busy !== 1'b0 || o_tok_cnt !== 8'd0 || o_num_valid !== 1'b0) begin bad++; $display("FAIL en_clear got busy=%0b cnt=%0d nv=%0b exp 0/0/0", o_busy, o_tok_cnt, o_num_valid); end
    total++; if (o_num !== 32'd42) begin bad++; $display("FAIL en_num_hold got=%0d exp=42", o_num); end
    send_byte(" "); send_byte("3"); send_byte(" ");
    total++; if (o_num_valid !== 1'b1 || o_num !== 32'd3 || o_tok_cnt !== 8'd1) begin bad++; $display("FAIL en_tok3 got nv=%0b num=%0d cnt=%0d exp 1/3/1", o_num_valid, o_num, o_tok_cnt); end
  endtask

  task automatic test_back_to_back;
    send_byte("x");
    total++; if (o_err !== 1'b1 || o_err_code !== 2'b01) begin bad++; $display("FAIL b2b_idle_ill got err=%0b code=%b exp 1/01", o_err, o_err_code); end
    send_byte("y");
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL b2b_skip_quiet got=%0b exp=0", o_err); end
    send_byte(8'h0D);
    total++; if (o_line_end !== 1'b1 || o_num_valid !== 1'b0) begin bad++; $display("FAIL b2b_skip_cr got le=%0b nv=%0b exp 1/0", o_line_end, o_num_valid); end
    send_byte(8'h0D);
    total++; if (o_line_end !== 1'b1) begin bad++; $display("FAIL b2b_cr_cr got=%0b exp=1", o_line_end); end
    send_byte(8'h0A);
    total++; if (o_line_end !== 1'b0) begin bad++; $display("FAIL b2b_crlf got=%0b exp=0", o_line_end); end
    send_byte(8'h0A);
    total++; if (o_line_end !== 1'b1) begin bad++; $display("FAIL b2b_lf_lf got=%0b exp=1", o_line_end); end
  endtask

  task automatic test_reset_mid;
    send_byte("5"); send_byte("6");
    #1; rst_n = 1'b0; #1;
    total++; if ({o_num_valid, o_line_end, o_err, o_busy} !== 4'b0000 || o_num !== '0) begin bad++; $display("FAIL rstm_out got pulses=%b num=%0d exp 0000/0", {o_num_valid, o_line_end, o_err, o_busy}, o_num); end
    total++; if (o_tok_cnt !== 8'd0 || o_err_code !== 2'b00) begin bad++; $display("FAIL rstm_cnt_code got=%0d/%b exp 0/00", o_tok_cnt, o_err_code); end
    @(posedge clk); #1; rst_n = 1'b1;
    send_byte(8'h0A);
    total++; if (o_line_end !== 1'b1 || o_num_valid !== 1'b0 || o_num !== '0) begin bad++; $display("FAIL rstm_lf got le=%0b nv=%0b num=%0d exp 1/0/0", o_line_end, o_num_valid, o_num); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_illegal();
    test_range();
    test_flush();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
